// File: rtl/operand_seq_pkg.sv
// -----------------------------------------------------------------------------
// operand_seq_pkg
// Shared definitions for the operand sequencer and the 7-bit bitwise unit it
// feeds: default operand/opcode widths, FSM state encoding (also shown on the
// state LEDs) and the opcode values understood by the bitwise unit.
// No ports; imported with "import operand_seq_pkg::*;".
// -----------------------------------------------------------------------------
package operand_seq_pkg;

  localparam int DATA_W = 7;
  localparam int OP_W   = 2;

  // Encodings are visible on state_out, so they are fixed explicitly.
  typedef enum logic [2:0] {
    GET_A  = 3'd0,
    GET_B  = 3'd1,
    GET_OP = 3'd2,
    ISSUE  = 3'd3,
    WAIT   = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_AND  = 2'b00;
  localparam logic [OP_W-1:0] OP_OR   = 2'b01;
  localparam logic [OP_W-1:0] OP_XOR  = 2'b10;
  localparam logic [OP_W-1:0] OP_NAND = 2'b11;

endpackage

// File: rtl/operand_sequencer_btn.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Turns one raw asynchronous push-button into a single-cycle event pulse:
// SYNC_STAGES-deep synchroniser, optional debounce filter, rising-edge detect.
// Optional feature macro: OPERAND_SEQ_DEBOUNCE_EN. When defined, the
// synchronised level must hold for DB_CYCLES consecutive cycles before the
// filtered level follows it; when undefined, no counter is built and edge
// detection runs straight on the synchronised level (DB_CYCLES unused).
// Ports:
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   btn   in  raw button, active-high, asynchronous to clk
//   evt   out one-cycle pulse per press (decoded from registered state)
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic evt
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_level_s;
  logic                   level_s;
  logic                   prev_r;

  // Synchroniser chain: new samples enter at bit 0, the MSB is the clean level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], btn};
    end
  end

  assign sync_level_s = sync_r[SYNC_STAGES-1];

`ifdef OPERAND_SEQ_DEBOUNCE_EN
  localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

  logic [DB_W-1:0] db_cnt_r;
  logic            flt_r;

  // Debounce: count consecutive cycles in which the synchronised level
  // disagrees with the filtered level; flip only after DB_CYCLES of them.
  // Any agreeing cycle restarts the count, so short glitches vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r <= {DB_W{1'b0}};
      flt_r    <= 1'b0;
    end else if (sync_level_s == flt_r) begin
      db_cnt_r <= {DB_W{1'b0}};
    end else if (db_cnt_r == DB_W'(DB_CYCLES - 1)) begin
      db_cnt_r <= {DB_W{1'b0}};
      flt_r    <= sync_level_s;
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  assign level_s = flt_r;
`else
  assign level_s = sync_level_s;
`endif

  // Previous-level register for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= level_s;
    end
  end

  // Held buttons give exactly one event: prev catches up one cycle later.
  assign evt = level_s & ~prev_r;

endmodule

// File: rtl/operand_sequencer.sv
// -----------------------------------------------------------------------------
// operand_sequencer
// Collects operand A, operand B and a 2-bit opcode from one shared switch bank
// (one value per load press), holds them stable for the downstream bitwise
// unit, pulses issue for one cycle, then pulses result_valid in the cycle the
// downstream registered result is valid. A clear press returns to GET_A and
// zeroes the operands from any state; clear beats a simultaneous load.
// Optional feature macro: OPERAND_SEQ_DEBOUNCE_EN (button debounce, see
// btn_conditioner).
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   sw           in   DATA_W switch bank, sampled on an accepted load
//   btn_load     in   raw load button
//   btn_clear    in   raw clear button
//   a_out        out  DATA_W registered operand A
//   b_out        out  DATA_W registered operand B
//   op_out       out  OP_W registered opcode (00 AND, 01 OR, 10 XOR, 11 NAND)
//   issue        out  one-cycle pulse, operands stable and new
//   result_valid out  one-cycle pulse, downstream result of last issue valid
//   state_out    out  3-bit FSM state for LEDs
// -----------------------------------------------------------------------------
module operand_sequencer #(
  parameter int DATA_W      = operand_seq_pkg::DATA_W,
  parameter int OP_W        = operand_seq_pkg::OP_W,
  parameter int SYNC_STAGES = 2,
  parameter int RESULT_LAT  = 1,
  parameter int DB_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sw,
  input  logic              btn_load,
  input  logic              btn_clear,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  output logic              issue,
  output logic              result_valid,
  output logic [2:0]        state_out
);

  import operand_seq_pkg::*;

  localparam int CNT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  logic              load_evt_s;
  logic              clr_evt_s;
  state_t            state_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [OP_W-1:0]   op_r;
  logic [CNT_W-1:0]  wait_cnt_r;
  logic              issue_r;
  logic              result_valid_r;

  btn_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_load_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_load),
    .evt   (load_evt_s)
  );

  btn_conditioner #(
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_clear_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .evt   (clr_evt_s)
  );

  // Sequencer FSM with its operand, counter and pulse registers.
  // issue_r is set on entry to ISSUE so it is high exactly while in ISSUE;
  // result_valid_r is set on entry to the WAIT cycle whose counter is 0, so
  // it is high exactly in that cycle. Both default low every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= GET_A;
      a_r            <= {DATA_W{1'b0}};
      b_r            <= {DATA_W{1'b0}};
      op_r           <= {OP_W{1'b0}};
      wait_cnt_r     <= {CNT_W{1'b0}};
      issue_r        <= 1'b0;
      result_valid_r <= 1'b0;
    end else if (clr_evt_s) begin
      // Clear wins over any load in the same cycle and aborts a pending result.
      state_r        <= GET_A;
      a_r            <= {DATA_W{1'b0}};
      b_r            <= {DATA_W{1'b0}};
      op_r           <= {OP_W{1'b0}};
      wait_cnt_r     <= {CNT_W{1'b0}};
      issue_r        <= 1'b0;
      result_valid_r <= 1'b0;
    end else begin
      issue_r        <= 1'b0;
      result_valid_r <= 1'b0;
      case (state_r)
        GET_A: begin
          if (load_evt_s) begin
            a_r     <= sw;
            state_r <= GET_B;
          end else begin
            state_r <= GET_A;
          end
        end
        GET_B: begin
          if (load_evt_s) begin
            b_r     <= sw;
            state_r <= GET_OP;
          end else begin
            state_r <= GET_B;
          end
        end
        GET_OP: begin
          if (load_evt_s) begin
            op_r    <= sw[OP_W-1:0];
            state_r <= ISSUE;
            issue_r <= 1'b1;
          end else begin
            state_r <= GET_OP;
          end
        end
        ISSUE: begin
          // Loads arriving here or in WAIT are dropped, never queued.
          state_r        <= WAIT;
          wait_cnt_r     <= CNT_W'(RESULT_LAT - 1);
          result_valid_r <= (RESULT_LAT == 1);
        end
        WAIT: begin
          if (wait_cnt_r == {CNT_W{1'b0}}) begin
            state_r <= GET_A;
          end else begin
            wait_cnt_r     <= wait_cnt_r - CNT_W'(1);
            result_valid_r <= (wait_cnt_r == CNT_W'(1));
            state_r        <= WAIT;
          end
        end
        default: begin
          // Unused codes recover to GET_A; operands are left untouched.
          state_r <= GET_A;
        end
      endcase
    end
  end

  assign a_out        = a_r;
  assign b_out        = b_r;
  assign op_out       = op_r;
  assign issue        = issue_r;
  assign result_valid = result_valid_r;
  assign state_out    = state_r;

endmodule

// File: tb/tb_operand_sequencer.sv
// -----------------------------------------------------------------------------
// tb_operand_sequencer
// Directed bench for operand_sequencer. Two instances: dut (RESULT_LAT = 1)
// and dut3 (RESULT_LAT = 3) with separate buttons and a shared switch bank.
// A small model of the registered downstream bitwise unit produces q.
// Optional feature macro: OPERAND_SEQ_DEBOUNCE_EN selects debounce timing.
// -----------------------------------------------------------------------------
module tb_operand_sequencer;

  localparam int SYNC = 2;
  localparam int DBC  = 16;
`ifdef OPERAND_SEQ_DEBOUNCE_EN
  localparam int PRESS_LAT = SYNC + DBC + 1;
`else
  localparam int PRESS_LAT = SYNC + 1;
`endif
  localparam int GAP = PRESS_LAT + 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] sw = 7'h00;
  logic       btn_load = 1'b0, btn_clear = 1'b0;
  logic       btn3_load = 1'b0, btn3_clear = 1'b0;

  logic [6:0] a, b, a3, b3;
  logic [1:0] op, op3;
  logic       issue, rv, issue3, rv3;
  logic [2:0] st, st3;

  int n_tests = 0;
  int n_fail  = 0;
  int issue_cnt = 0, rv_cnt = 0, issue3_cnt = 0, rv3_cnt = 0;
  int ic, rc;
  logic [6:0] q_model = 7'h00;

  always #5 clk = ~clk;

  operand_sequencer #(.DATA_W(7), .OP_W(2), .SYNC_STAGES(SYNC), .RESULT_LAT(1), .DB_CYCLES(DBC)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn_load), .btn_clear(btn_clear),
    .a_out(a), .b_out(b), .op_out(op), .issue(issue), .result_valid(rv), .state_out(st));

  operand_sequencer #(.DATA_W(7), .OP_W(2), .SYNC_STAGES(SYNC), .RESULT_LAT(3), .DB_CYCLES(DBC)) dut3 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_load(btn3_load), .btn_clear(btn3_clear),
    .a_out(a3), .b_out(b3), .op_out(op3), .issue(issue3), .result_valid(rv3), .state_out(st3));

  // Pulse counters and the downstream one-cycle registered bitwise unit model.
  always @(posedge clk) begin
    if (issue)  issue_cnt  <= issue_cnt + 1;
    if (rv)     rv_cnt     <= rv_cnt + 1;
    if (issue3) issue3_cnt <= issue3_cnt + 1;
    if (rv3)    rv3_cnt    <= rv3_cnt + 1;
    case (op)
      2'b00:   q_model <= a & b;
      2'b01:   q_model <= a | b;
      2'b10:   q_model <= a ^ b;
      default: q_model <= ~(a & b);
    endcase
  end

  task automatic drive_btn(input int which, input logic val);
    case (which)
      0: btn_load   = val;
      1: btn_clear  = val;
      2: btn3_load  = val;
      default: btn3_clear = val;
    endcase
  endtask

  // Called at a negedge; returns at the negedge just after the acting edge
  // when hold == PRESS_LAT.
  task automatic press(input int which, input int hold);
    drive_btn(which, 1'b1);
    repeat (hold) @(negedge clk);
    drive_btn(which, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    if ({st, a, b, op} !== 19'h0) begin $display("FAIL reset_regs: got %h expected 0", {st, a, b, op}); n_fail++; end n_tests++;
    if ({issue, rv} !== 2'b00) begin $display("FAIL reset_pulses: got %b expected 00", {issue, rv}); n_fail++; end n_tests++;
    if ({st3, a3, b3, op3, issue3, rv3} !== 21'h0) begin $display("FAIL reset_dut3: got %h expected 0", {st3, a3, b3, op3, issue3, rv3}); n_fail++; end n_tests++;
    rst_n = 1'b1;
    idle(2);
    if (st !== 3'd0) begin $display("FAIL reset_release_state: got %0d expected 0", st); n_fail++; end n_tests++;
  endtask

  task automatic test_basic;
    sw = 7'h55; press(0, PRESS_LAT);
    if (a !== 7'h55 || st !== 3'd1) begin $display("FAIL basic_a: got a=%h st=%0d expected a=55 st=1", a, st); n_fail++; end n_tests++;
    idle(GAP);
    sw = 7'h0F; press(0, PRESS_LAT);
    if (b !== 7'h0F || st !== 3'd2) begin $display("FAIL basic_b: got b=%h st=%0d expected b=0f st=2", b, st); n_fail++; end n_tests++;
    idle(GAP);
    sw = 7'h02; press(0, PRESS_LAT);
    if (issue !== 1'b1 || st !== 3'd3) begin $display("FAIL basic_issue: got issue=%b st=%0d expected 1 3", issue, st); n_fail++; end n_tests++;
    if ({a, b, op} !== {7'h55, 7'h0F, 2'b10}) begin $display("FAIL basic_operands: got %h %h %b expected 55 0f 10", a, b, op); n_fail++; end n_tests++;
    idle(1);
    if (issue !== 1'b0 || rv !== 1'b1 || st !== 3'd4) begin $display("FAIL basic_rv: got issue=%b rv=%b st=%0d expected 0 1 4", issue, rv, st); n_fail++; end n_tests++;
    if (q_model !== 7'h5A) begin $display("FAIL basic_q: got %h expected 5a", q_model); n_fail++; end n_tests++;
    idle(1);
    if (rv !== 1'b0 || st !== 3'd0 || a !== 7'h55) begin $display("FAIL basic_return: got rv=%b st=%0d a=%h expected 0 0 55", rv, st, a); n_fail++; end n_tests++;
    idle(2);
    if (issue_cnt !== 1 || rv_cnt !== 1) begin $display("FAIL basic_pulse_count: got %0d %0d expected 1 1", issue_cnt, rv_cnt); n_fail++; end n_tests++;
    idle(GAP);
  endtask

  task automatic test_held_button;
    sw = 7'h7F; press(0, 50);
    if (a !== 7'h7F || st !== 3'd1 || b !== 7'h0F) begin $display("FAIL held_once: got a=%h st=%0d b=%h expected 7f 1 0f", a, st, b); n_fail++; end n_tests++;
    idle(GAP);
    if (st !== 3'd1) begin $display("FAIL held_no_advance: got %0d expected 1", st); n_fail++; end n_tests++;
    sw = 7'h33; press(0, PRESS_LAT);
    if (b !== 7'h33 || st !== 3'd2) begin $display("FAIL held_repress: got b=%h st=%0d expected 33 2", b, st); n_fail++; end n_tests++;
    idle(GAP);
  endtask

  task automatic test_clear_mid;
    press(1, PRESS_LAT);
    if ({st, a, b, op} !== 19'h0) begin $display("FAIL clear_getop: got %h expected 0", {st, a, b, op}); n_fail++; end n_tests++;
    idle(GAP);
    sw = 7'h11; press(0, PRESS_LAT); idle(GAP);
    sw = 7'h22; press(0, PRESS_LAT);
    if (a !== 7'h11 || b !== 7'h22 || st !== 3'd2) begin $display("FAIL clear_setup: got a=%h b=%h st=%0d expected 11 22 2", a, b, st); n_fail++; end n_tests++;
    idle(GAP);
    ic = issue_cnt; rc = rv_cnt;
    press(1, PRESS_LAT);
    if ({st, a, b, op} !== 19'h0) begin $display("FAIL clear_mid: got %h expected 0", {st, a, b, op}); n_fail++; end n_tests++;
    idle(GAP);
    if (issue_cnt !== ic || rv_cnt !== rc) begin $display("FAIL clear_no_pulse: got %0d %0d expected %0d %0d", issue_cnt, rv_cnt, ic, rc); n_fail++; end n_tests++;
  endtask

  task automatic test_simultaneous;
    sw = 7'h44; press(0, PRESS_LAT);
    if (a !== 7'h44 || st !== 3'd1) begin $display("FAIL simul_setup: got a=%h st=%0d expected 44 1", a, st); n_fail++; end n_tests++;
    idle(GAP);
    btn_load = 1'b1; btn_clear = 1'b1;
    idle(PRESS_LAT);
    btn_load = 1'b0; btn_clear = 1'b0;
    if ({st, a, b, op} !== 19'h0) begin $display("FAIL simul_clear_wins: got %h expected 0", {st, a, b, op}); n_fail++; end n_tests++;
    idle(GAP);
  endtask

`ifndef OPERAND_SEQ_DEBOUNCE_EN
  task automatic test_wait_rl3;
    sw = 7'h03; press(2, PRESS_LAT); idle(GAP);
    sw = 7'h05; press(2, PRESS_LAT); idle(GAP);
    rc = rv3_cnt; ic = issue3_cnt;
    sw = 7'h02; press(2, PRESS_LAT);
    if (issue3 !== 1'b1 || st3 !== 3'd3 || op3 !== 2'b10) begin $display("FAIL rl3_issue: got issue=%b st=%0d op=%b expected 1 3 10", issue3, st3, op3); n_fail++; end n_tests++;
    @(negedge clk); btn3_load = 1'b1;  // re-press lands in the last WAIT cycle
    if (st3 !== 3'd4 || rv3 !== 1'b0 || issue3 !== 1'b0) begin $display("FAIL rl3_wait1: got st=%0d rv=%b issue=%b expected 4 0 0", st3, rv3, issue3); n_fail++; end n_tests++;
    @(negedge clk);
    if (st3 !== 3'd4 || rv3 !== 1'b0) begin $display("FAIL rl3_wait2: got st=%0d rv=%b expected 4 0", st3, rv3); n_fail++; end n_tests++;
    @(negedge clk);
    if (st3 !== 3'd4 || rv3 !== 1'b1) begin $display("FAIL rl3_valid: got st=%0d rv=%b expected 4 1", st3, rv3); n_fail++; end n_tests++;
    @(negedge clk);
    btn3_load = 1'b0;
    if (st3 !== 3'd0 || rv3 !== 1'b0 || a3 !== 7'h03) begin $display("FAIL rl3_drop: got st=%0d rv=%b a=%h expected 0 0 03", st3, rv3, a3); n_fail++; end n_tests++;
    idle(GAP);
    if (st3 !== 3'd0 || rv3_cnt !== rc + 1 || issue3_cnt !== ic + 1) begin $display("FAIL rl3_counts: got st=%0d rv=%0d issue=%0d expected 0 %0d %0d", st3, rv3_cnt, issue3_cnt, rc + 1, ic + 1); n_fail++; end n_tests++;
    sw = 7'h06; press(2, PRESS_LAT);
    if (a3 !== 7'h06 || st3 !== 3'd1) begin $display("FAIL rl3_restart: got a=%h st=%0d expected 06 1", a3, st3); n_fail++; end n_tests++;
    idle(GAP);
  endtask

  task automatic test_clear_in_wait;
    sw = 7'h07; press(2, PRESS_LAT); idle(GAP);
    rc = rv3_cnt;
    sw = 7'h02; press(2, PRESS_LAT);
    press(3, PRESS_LAT);  // clear acts on the edge that would raise result_valid
    if ({st3, a3, b3, op3, rv3} !== 20'h0) begin $display("FAIL wait_clear: got %h expected 0", {st3, a3, b3, op3, rv3}); n_fail++; end n_tests++;
    idle(3);
    if (rv3_cnt !== rc) begin $display("FAIL wait_clear_no_rv: got %0d expected %0d", rv3_cnt, rc); n_fail++; end n_tests++;
    idle(GAP);
  endtask

  task automatic test_async_reset;
    sw = 7'h01; press(2, PRESS_LAT); idle(GAP);
    sw = 7'h09; press(2, PRESS_LAT); idle(GAP);
    sw = 7'h03; press(2, PRESS_LAT);
    @(posedge clk); #2;
    if (st3 !== 3'd4) begin $display("FAIL async_setup: got st=%0d expected 4", st3); n_fail++; end n_tests++;
    rst_n = 1'b0;
    #1;
    if ({st3, a3, b3, op3, issue3, rv3} !== 21'h0) begin $display("FAIL async_immediate: got %h expected 0", {st3, a3, b3, op3, issue3, rv3}); n_fail++; end n_tests++;
    @(negedge clk); rst_n = 1'b1;
    idle(2);
    if (st3 !== 3'd0 || st !== 3'd0) begin $display("FAIL async_release: got %0d %0d expected 0 0", st3, st); n_fail++; end n_tests++;
  endtask
`else
  task automatic test_debounce;
    sw = 7'h2A;
    btn_load = 1'b1; idle(10); btn_load = 1'b0;
    idle(30);
    if (st !== 3'd0 || a !== 7'h00) begin $display("FAIL db_glitch: got st=%0d a=%h expected 0 00", st, a); n_fail++; end n_tests++;
    btn_load = 1'b1;
    idle(SYNC + DBC);
    if (st !== 3'd0) begin $display("FAIL db_early: got %0d expected 0", st); n_fail++; end n_tests++;
    idle(1);
    if (st !== 3'd1 || a !== 7'h2A) begin $display("FAIL db_press: got st=%0d a=%h expected 1 2a", st, a); n_fail++; end n_tests++;
    idle(1); btn_load = 1'b0;
    idle(GAP);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_held_button();
    test_clear_mid();
    test_simultaneous();
`ifndef OPERAND_SEQ_DEBOUNCE_EN
    test_wait_rl3();
    test_clear_in_wait();
    test_async_reset();
`else
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
Name: operand_sequencer

Overview:
- Upstream stage that feeds the 7-bit bitwise operation unit.
- Collects operand A, operand B and a 2-bit opcode from one shared switch bank, one value per press of a load button.
- Holds the three values stable and issues a one-cycle go pulse.
- Flags the cycle in which the downstream registered result is valid, so a display or capture stage can latch it.

Parameters:
- DATA_W, 7, operand width (a_out, b_out, sw).
- OP_W, 2, opcode width.
- SYNC_STAGES, 2, flip-flop depth of the button synchronisers (minimum 2).
- RESULT_LAT, 1, cycles from issue to valid downstream result (minimum 1).
- DB_CYCLES, 16, debounce stable-count (used only with DEBOUNCE_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sw  in  DATA_W  switch bank; quasi-static, sampled only on an accepted load.
- btn_load  in  1  raw load push-button, asynchronous, active-high.
- btn_clear  in  1  raw clear push-button, asynchronous, active-high.
- a_out  out  DATA_W  registered operand A.
- b_out  out  DATA_W  registered operand B.
- op_out  out  OP_W  registered opcode (00 AND, 01 OR, 10 XOR, 11 NAND).
- issue  out  1  one-cycle pulse; operands are stable and new.
- result_valid  out  1  one-cycle pulse; downstream q holds the result of the last issue.
- state_out  out  3  current FSM state encoding, for LEDs.

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - state GET_A
  - a_out = 0, b_out = 0, op_out = 0
  - issue = 0, result_valid = 0
  - synchronisers and edge registers = 0
- Release of reset is synchronous through the normal clock; the first active edge after release starts in GET_A.
- Button path:
  - Each button passes through SYNC_STAGES flops and then a rising-edge detector (sync_out & ~prev).
  - A press produces exactly one load_evt or clr_evt cycle, however long the button is held.
  - The FSM acts on the edge that is SYNC_STAGES+1 clocks after the first high sample.
- States, with encoding in state_out:
  - GET_A (0): on load_evt, a_out <= sw; go to GET_B.
  - GET_B (1): on load_evt, b_out <= sw; go to GET_OP.
  - GET_OP (2): on load_evt, op_out <= sw[OP_W-1:0] (upper switch bits ignored); go to ISSUE.
  - ISSUE (3): issue = 1 for this single cycle; load wait counter with RESULT_LAT-1; go to WAIT.
  - WAIT (4): when the counter is 0, result_valid = 1 for one cycle and go to GET_A; otherwise decrement.
- Timing: with RESULT_LAT = 1, issue is high in cycle N and result_valid in cycle N+1. This matches the one-cycle registered downstream unit.
- issue and result_valid are registered outputs decoded from the state and counter.
- Load events in ISSUE or WAIT are dropped, not queued.
- clr_evt in any state:
  - next state GET_A; a_out, b_out, op_out <= 0.
  - Any pending result_valid is aborted; issue and result_valid are 0 in the following cycle.
- Simultaneous clr_evt and load_evt: clear wins and the load is discarded.
- Output holding: a_out, b_out and op_out hold their values between updates. After result_valid they remain at the last operands until overwritten by the next cycle of loads.
- Unused state codes 5-7 recover to GET_A on the next edge, with outputs unchanged.

Optional Feature:
- Macro: OPERAND_SEQ_DEBOUNCE_EN.
- Defined:
  - After synchronisation, each button must be stable for DB_CYCLES consecutive cycles before its filtered level changes.
  - Edge detection runs on the filtered level.
  - Press latency becomes SYNC_STAGES+DB_CYCLES+1 cycles.
  - Glitches shorter than DB_CYCLES produce no event.
- Undefined:
  - No debounce counter is built.
  - Edge detection runs directly on the synchronised level.
  - DB_CYCLES is ignored.

Decomposition:
- Shared package operand_seq_pkg contains:
  - State enum (GET_A, GET_B, GET_OP, ISSUE, WAIT).
  - Opcode constants OP_AND, OP_OR, OP_XOR, OP_NAND.
  - DATA_W and OP_W defaults, reused by the bitwise unit and its bench.
- One sub-module, btn_conditioner: synchroniser, optional debounce and rising-edge detect.
  - Parameterised by SYNC_STAGES and DB_CYCLES.
  - Instantiated twice (load and clear).
- The FSM and output registers live in the top.

Test Plan (macro undefined unless noted):
- Basic sequence: reset, then loads with sw = 7'h55, 7'h0F, 7'h02.
  - a_out = 55, b_out = 0F, op_out = 10.
  - issue pulses exactly once, one cycle after the third event.
  - result_valid pulses the next cycle.
  - With the bitwise unit attached, q = 7'h5A in the result_valid cycle.
- Held button: btn_load held high for 50 cycles in GET_A with sw = 7'h7F.
  - Only a_out updates (= 7F); state is GET_B.
  - No further advance until the button is released and pressed again.
- Clear mid-operation: after A = 7'h11 and B = 7'h22, press clear.
  - state GET_A; a_out = b_out = op_out = 0.
  - No issue and no result_valid pulse.
  - Clear pressed during WAIT with RESULT_LAT = 3 likewise suppresses result_valid.
- Dropped loads and simultaneous events:
  - Load pulses during ISSUE/WAIT are ignored; the next sequence starts cleanly at GET_A.
  - Simultaneous load and clear events: state GET_A, outputs 0.
- Async reset: assert rst_n low mid-WAIT between clock edges.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - state_out = 0 after release.
- OPERAND_SEQ_DEBOUNCE_EN defined, DB_CYCLES = 16:
  - A 10-cycle glitch on btn_load produces no event.
  - A 20-cycle press produces one event, SYNC_STAGES+17 cycles after onset.
